// File: rtl/count_pair_pkg.sv
// rtl/count_pair_pkg.sv - shared types and constants for the count pair monitor
package count_pair_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    // The up/down pair keeps this sum constant under every legal transition
    function automatic cnt_t pair_sum(input cnt_t a, input cnt_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/count_pair_monitor_if.sv
// rtl/count_pair_monitor_if.sv - observed counter pair and monitor status bundle
interface count_pair_monitor_if #(
    parameter int ERR_W = 8
);
    import count_pair_pkg::*;

    logic             enable;
    logic             swap;
    cnt_t             upcount;
    cnt_t             downcount;
    logic             resync;
    logic             locked;
    logic             mismatch;
    logic             fault;
    logic [ERR_W-1:0] err_count;
    cnt_t             sum_ref;

    modport master (
        output enable, swap, upcount, downcount, resync,
        input  locked, mismatch, fault, err_count, sum_ref
    );

    modport slave (
        input  enable, swap, upcount, downcount, resync,
        output locked, mismatch, fault, err_count, sum_ref
    );

endinterface

// File: rtl/count_pair_predict.sv
// rtl/count_pair_predict.sv - next up/down pair predicted from the previous sample
module count_pair_predict
    import count_pair_pkg::*;
(
    input  logic i_enable,
    input  logic i_swap,
    input  cnt_t i_up,
    input  cnt_t i_down,
    output cnt_t o_up,
    output cnt_t o_down
);

    always_comb begin
        o_up   = i_up;
        o_down = i_down;
        if (i_enable) begin
            if (i_swap) begin
                o_up   = i_down;
                o_down = i_up;
            end else begin
                o_up   = i_up + CNT_W'(1);
                o_down = i_down - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/count_pair_monitor.sv
// rtl/count_pair_monitor.sv - lock/check/fault monitor for an up/down counter pair
module count_pair_monitor
    import count_pair_pkg::*;
#(
    parameter int FAULT_LIMIT = 3,
    parameter int ERR_W       = 8
) (
    input logic                clock,
    input logic                reset_n,
    count_pair_monitor_if.slave bus
);

    localparam int FC_W = (FAULT_LIMIT < 2) ? 1 : $clog2(FAULT_LIMIT + 1);
    localparam logic [FC_W-1:0] FC_LIMIT = FC_W'(FAULT_LIMIT);

    state_t           r_state, w_state_nxt;
    logic             r_prev_en, r_prev_swap;
    cnt_t             r_prev_up, r_prev_down;
    cnt_t             r_sum_ref, w_sum_ref_nxt;
    logic [FC_W-1:0]  r_fail_cnt, w_fail_cnt_nxt, w_fail_inc;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;
    logic             r_mismatch, w_mismatch_nxt;
    cnt_t             w_exp_up, w_exp_down, w_cur_sum;
    logic             w_fail;

    count_pair_predict u_predict (
        .i_enable (r_prev_en),
        .i_swap   (r_prev_swap),
        .i_up     (r_prev_up),
        .i_down   (r_prev_down),
        .o_up     (w_exp_up),
        .o_down   (w_exp_down)
    );

    assign w_cur_sum  = pair_sum(bus.upcount, bus.downcount);
    assign w_fail     = (bus.upcount != w_exp_up) || (bus.downcount != w_exp_down) ||
                        (w_cur_sum != r_sum_ref);
    assign w_fail_inc = r_fail_cnt + FC_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_UNLOCKED;
            r_prev_en   <= 1'b0;
            r_prev_swap <= 1'b0;
            r_prev_up   <= '0;
            r_prev_down <= '0;
            r_sum_ref   <= '0;
            r_fail_cnt  <= '0;
            r_err_cnt   <= '0;
            r_mismatch  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_en   <= bus.enable;
            r_prev_swap <= bus.swap;
            r_prev_up   <= bus.upcount;
            r_prev_down <= bus.downcount;
            r_sum_ref   <= w_sum_ref_nxt;
            r_fail_cnt  <= w_fail_cnt_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_mismatch  <= w_mismatch_nxt;
        end
    end

    // resync outranks any check on the same edge and never touches err_count
    always_comb begin
        w_state_nxt    = r_state;
        w_sum_ref_nxt  = r_sum_ref;
        w_fail_cnt_nxt = r_fail_cnt;
        w_err_cnt_nxt  = r_err_cnt;
        w_mismatch_nxt = 1'b0;
        if (bus.resync) begin
            w_state_nxt    = ST_UNLOCKED;
            w_fail_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    w_state_nxt   = ST_LOCKED;
                    w_sum_ref_nxt = w_cur_sum;
                end
                ST_LOCKED: begin
                    if (w_fail) begin
                        w_mismatch_nxt = 1'b1;
                        w_fail_cnt_nxt = w_fail_inc;
                        if (r_err_cnt != {ERR_W{1'b1}}) begin
                            w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
                        end
                        if (w_fail_inc == FC_LIMIT) begin
                            w_state_nxt = ST_FAULT;
                        end
                    end else begin
                        w_fail_cnt_nxt = '0;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign bus.locked    = (r_state == ST_LOCKED);
    assign bus.fault     = (r_state == ST_FAULT);
    assign bus.mismatch  = r_mismatch;
    assign bus.err_count = r_err_cnt;
    assign bus.sum_ref   = r_sum_ref;

endmodule

// File: tb/tb_count_pair_monitor.sv
// tb/tb_count_pair_monitor.sv - randomized model-checked bench for count_pair_monitor
module tb_count_pair_monitor;

    typedef struct {
        int st;
        int pen, psw, pup, pdn;
        int sref, fcnt, err, mis;
    } mdl_t;

    logic clk;
    logic rst_n;
    logic t_en, t_sw, t_rs;
    logic [3:0] t_up, t_dn;

    int n_tot = 0;
    int n_bad = 0;
    int l_en = 0, l_sw = 0, l_up = 0, l_dn = 0;
    mdl_t ma, mb;

    count_pair_monitor_if #(.ERR_W(8)) if_a ();
    count_pair_monitor_if #(.ERR_W(2)) if_b ();

    assign if_a.enable = t_en;  assign if_b.enable = t_en;
    assign if_a.swap = t_sw;    assign if_b.swap = t_sw;
    assign if_a.upcount = t_up; assign if_b.upcount = t_up;
    assign if_a.downcount = t_dn; assign if_b.downcount = t_dn;
    assign if_a.resync = t_rs;  assign if_b.resync = t_rs;

    count_pair_monitor #(.FAULT_LIMIT(3), .ERR_W(8)) dut_a (.clock(clk), .reset_n(rst_n), .bus(if_a));
    count_pair_monitor #(.FAULT_LIMIT(3), .ERR_W(2)) dut_b (.clock(clk), .reset_n(rst_n), .bus(if_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pred_up(input int en, input int sw, input int up, input int dn);
        if (en == 0) return up;
        if (sw != 0) return dn;
        return (up + 1) % 16;
    endfunction

    function automatic int pred_dn(input int en, input int sw, input int up, input int dn);
        if (en == 0) return dn;
        if (sw != 0) return up;
        return (dn + 15) % 16;
    endfunction

    function automatic mdl_t mzero();
        mdl_t m;
        m.st = 0; m.pen = 0; m.psw = 0; m.pup = 0; m.pdn = 0;
        m.sref = 0; m.fcnt = 0; m.err = 0; m.mis = 0;
        return m;
    endfunction

    // st: 0 = unlocked, 1 = locked, 2 = fault
    function automatic mdl_t mstep(input mdl_t m, input int en, input int sw, input int up,
                                   input int dn, input int rs, input int errmax);
        mdl_t n;
        int eu, ed;
        bit f;
        n = m;
        n.mis = 0;
        if (rs != 0) begin
            n.st = 0;
            n.fcnt = 0;
        end else if (m.st == 0) begin
            n.st = 1;
            n.sref = (up + dn) % 16;
        end else if (m.st == 1) begin
            eu = pred_up(m.pen, m.psw, m.pup, m.pdn);
            ed = pred_dn(m.pen, m.psw, m.pup, m.pdn);
            f = (up != eu) || (dn != ed) || (((up + dn) % 16) != m.sref);
            if (f) begin
                n.mis = 1;
                if (n.err < errmax) n.err = n.err + 1;
                n.fcnt = n.fcnt + 1;
                if (n.fcnt >= 3) n.st = 2;
            end else begin
                n.fcnt = 0;
            end
        end
        n.pen = en; n.psw = sw; n.pup = up; n.pdn = dn;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mzero();
            mb <= mzero();
        end else begin
            ma <= mstep(ma, int'(t_en), int'(t_sw), int'(t_up), int'(t_dn), int'(t_rs), 255);
            mb <= mstep(mb, int'(t_en), int'(t_sw), int'(t_up), int'(t_dn), int'(t_rs), 3);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("a.locked", int'(if_a.locked), int'(ma.st == 1));
            chk("a.fault", int'(if_a.fault), int'(ma.st == 2));
            chk("a.mismatch", int'(if_a.mismatch), ma.mis);
            chk("a.err_count", int'(if_a.err_count), ma.err);
            chk("a.sum_ref", int'(if_a.sum_ref), ma.sref);
            chk("b.locked", int'(if_b.locked), int'(mb.st == 1));
            chk("b.fault", int'(if_b.fault), int'(mb.st == 2));
            chk("b.mismatch", int'(if_b.mismatch), mb.mis);
            chk("b.err_count", int'(if_b.err_count), mb.err);
            chk("b.sum_ref", int'(if_b.sum_ref), mb.sref);
        end
    end

    task automatic set_in(input int en, input int sw, input int up, input int dn, input int rs);
        t_en = en[0]; t_sw = sw[0]; t_up = up[3:0]; t_dn = dn[3:0]; t_rs = rs[0];
        l_en = en; l_sw = sw; l_up = up % 16; l_dn = dn % 16;
    endtask

    task automatic drive(input int en, input int sw, input int up, input int dn, input int rs);
        set_in(en, sw, up, dn, rs);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic good(input int en, input int sw, input int rs);
        drive(en, sw, pred_up(l_en, l_sw, l_up, l_dn), pred_dn(l_en, l_sw, l_up, l_dn), rs);
    endtask

    task automatic inj(input int en, input int sw, input int rs);
        drive(en, sw, pred_up(l_en, l_sw, l_up, l_dn) ^ 8, pred_dn(l_en, l_sw, l_up, l_dn), rs);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".a.locked"}, int'(if_a.locked), 0);
        chk({tag, ".a.mismatch"}, int'(if_a.mismatch), 0);
        chk({tag, ".a.fault"}, int'(if_a.fault), 0);
        chk({tag, ".a.err_count"}, int'(if_a.err_count), 0);
        chk({tag, ".a.sum_ref"}, int'(if_a.sum_ref), 0);
        chk({tag, ".b.err_count"}, int'(if_b.err_count), 0);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 check_zero("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int mis_seen;
        int r, en, sw;
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        do_reset();

        // Free-run from 0/15 through the wrap; last sample carries swap
        mis_seen = 0;
        drive(1, 0, 0, 15, 0);
        for (int i = 1; i < 20; i++) begin
            good(1, (i == 19) ? 1 : 0, 0);
            if (if_a.mismatch) mis_seen++;
        end
        chk("fr.locked", int'(if_a.locked), 1);
        chk("fr.sum_ref", int'(if_a.sum_ref), 15);
        chk("fr.err_count", int'(if_a.err_count), 0);
        chk("fr.mismatch_seen", mis_seen, 0);
        chk("fr.last_up", l_up, 3);

        good(0, 0, 0);
        chk("sw.up_is_12", l_up, 12);
        chk("sw.mismatch", int'(if_a.mismatch), 0);
        good(0, 0, 0);
        chk("hold1.mismatch", int'(if_a.mismatch), 0);
        good(1, 0, 0);
        chk("hold2.mismatch", int'(if_a.mismatch), 0);
        chk("hold2.up_is_12", l_up, 12);

        for (int i = 0; i < 16 && pred_up(l_en, l_sw, l_up, l_dn) != 5; i++) good(1, 0, 0);
        drive(1, 0, 9, pred_dn(l_en, l_sw, l_up, l_dn), 0);
        chk("corr.mismatch", int'(if_a.mismatch), 1);
        chk("corr.err_count", int'(if_a.err_count), 1);
        chk("corr.locked", int'(if_a.locked), 1);
        good(1, 0, 1);
        chk("corr.pulse_once", int'(if_a.mismatch), 0);
        chk("corr.unlocked", int'(if_a.locked), 0);
        good(1, 0, 0);
        chk("corr.relock", int'(if_a.locked), 1);
        chk("corr.err_kept", int'(if_a.err_count), 1);

        do_reset();
        drive(1, 0, 7, 8, 0);
        for (int i = 0; i < 3; i++) good(1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            inj(1, 0, 0);
            chk("flt.err_step", int'(if_a.err_count), i);
            chk("flt.fault_step", int'(if_a.fault), (i == 3) ? 1 : 0);
        end
        chk("flt.locked", int'(if_a.locked), 0);
        inj(1, 0, 0);
        inj(0, 0, 0);
        chk("flt.err_hold", int'(if_a.err_count), 3);
        chk("flt.no_mismatch", int'(if_a.mismatch), 0);
        chk("flt.still_fault", int'(if_a.fault), 1);
        good(1, 0, 1);
        chk("flt.resync_fault", int'(if_a.fault), 0);
        chk("flt.resync_locked", int'(if_a.locked), 0);
        good(1, 0, 0);
        chk("flt.relock", int'(if_a.locked), 1);
        chk("flt.err_kept", int'(if_a.err_count), 3);

        do_reset();
        drive(1, 0, 2, 5, 0);
        good(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            inj(1, 0, 0);
            good(1, 0, 1);
            good(1, 0, 0);
            good(1, 0, 0);
        end
        chk("sat.b.err_count", int'(if_b.err_count), 3);
        chk("sat.a.err_count", int'(if_a.err_count), 5);
        chk("sat.b.locked", int'(if_b.locked), 1);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            en = $urandom_range(0, 3) != 0 ? 1 : 0;
            sw = $urandom_range(0, 3) == 0 ? 1 : 0;
            if (r >= 4 && r < 12) inj(en, sw, 0);
            else good(en, sw, (r < 4) ? 1 : 0);
        end

        good(1, 0, 1);
        for (int i = 0; i < 3; i++) good(1, 0, 0);
        set_in(1, 0, pred_up(l_en, l_sw, l_up, l_dn) ^ 8, pred_dn(l_en, l_sw, l_up, l_dn), 0);
        @(posedge clk);
        #1 chk("mr.pending", int'(if_a.mismatch), 1);
        rst_n = 1'b0;
        #1 check_zero("mr");
        chk("mr.b.locked", int'(if_b.locked), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        good(1, 0, 0);
        chk("mr.lock.mismatch", int'(if_a.mismatch), 0);
        chk("mr.lock.locked", int'(if_a.locked), 1);
        good(1, 0, 0);
        chk("mr.after.mismatch", int'(if_a.mismatch), 0);
        chk("mr.after.err_count", int'(if_a.err_count), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
